// File: rtl/video_pattern_gen.sv
// Purpose: follows the timing generator's hs/vs/de, tracks active x/y and drives a 24-bit RGB test pattern.
// Latency: exactly 2 clk from hs_i/vs_i/de_i to hs_o/vs_o/de_o/rgb_o (stage 1 = coordinates, stage 2 = colour).
// Backpressure: none; a free-running pixel stream that never stalls, so every input cycle yields one output cycle.
module video_pattern_gen #(
  parameter int H_ACTIVE     = 8,
  parameter int V_ACTIVE     = 6,
  parameter int SYNC_ACT_LOW = 1,
  parameter int CHK_SHIFT    = 0,
  parameter int MOVE_STEP    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs_i,
  input  logic        vs_i,
  input  logic        de_i,
  input  logic [2:0]  pat_sel,
  input  logic [23:0] solid_rgb,
  output logic        hs_o,
  output logic        vs_o,
  output logic        de_o,
  output logic [23:0] rgb_o,
  output logic [15:0] frame_cnt,
  output logic        line_err
);

  // x needs one spare bit so over-long runs are still distinguishable from H_ACTIVE-1
  localparam int XW    = $clog2(H_ACTIVE) + 1;
  localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int BAR_W = H_ACTIVE / 8;

  localparam logic          SYNC_IDLE = (SYNC_ACT_LOW != 0);
  localparam logic [XW-1:0] X_MAX     = '1;
  localparam logic [XW-1:0] X_LAST    = XW'(H_ACTIVE - 1);
  localparam logic [XW-1:0] BAR_LAST  = XW'(BAR_W - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(V_ACTIVE - 1);
  localparam logic [XW:0]   H_EXT     = (XW+1)'(H_ACTIVE);
  localparam logic [XW:0]   STEP_EXT  = (XW+1)'(MOVE_STEP);
  localparam logic [XW:0]   BAR_EXT   = (XW+1)'(BAR_W);

  // stage 1 registers
  logic          hs_s1;
  logic          vs_s1;
  logic          de_s1;
  logic [XW-1:0] x_s1;
  logic [XW-1:0] bar_px_s1;
  logic [2:0]    bar_idx_s1;

  // frame-level state
  logic [YW-1:0] y_cnt;
  logic [2:0]    pat_q;
  logic [XW-1:0] bar_pos;
  logic          frame_seen;
  logic          chk_run;

  // combinational helpers
  logic          frame_start;
  logic          run_start;
  logic          run_end;
  logic [XW-1:0] x_nxt;
  logic [XW-1:0] bar_px_nxt;
  logic [2:0]    bar_idx_nxt;
  logic [XW:0]   bp_sum;
  logic [XW-1:0] bp_next;
  logic [23:0]   pix;
  logic [7:0]    grad;
  logic [XW:0]   x_ext;
  logic [XW:0]   bp_ext;

  // vs edge is detected against the stage-1 copy, so a de-high pixel on the
  // edge cycle already sees y=0 and the new pattern
  assign frame_start = (vs_i ^ SYNC_IDLE) & ~(vs_s1 ^ SYNC_IDLE);
  assign run_start   = de_i & ~de_s1;
  assign run_end     = ~de_i & de_s1;

  // coordinates of the pixel presented this cycle; bars advance every BAR_W pixels
  always_comb begin
    x_nxt       = x_s1;
    bar_px_nxt  = bar_px_s1;
    bar_idx_nxt = bar_idx_s1;
    if (run_start) begin
      x_nxt       = '0;
      bar_px_nxt  = '0;
      bar_idx_nxt = 3'd0;
    end else if (de_i) begin
      if (x_s1 != X_MAX) begin
        x_nxt = x_s1 + 1'b1;
      end
      if (bar_px_s1 == BAR_LAST) begin
        bar_px_nxt = '0;
        if (bar_idx_s1 != 3'd7) begin
          bar_idx_nxt = bar_idx_s1 + 3'd1;
        end
      end else begin
        bar_px_nxt = bar_px_s1 + 1'b1;
      end
    end
  end

  // moving bar position wraps modulo H_ACTIVE without a divider
  always_comb begin
    bp_sum  = {1'b0, bar_pos} + STEP_EXT;
    bp_next = (bp_sum >= H_EXT) ? XW'(bp_sum - H_EXT) : XW'(bp_sum);
  end

  // stage 1: delay syncs/de and hold the per-pixel coordinates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_s1      <= SYNC_IDLE;
      vs_s1      <= SYNC_IDLE;
      de_s1      <= 1'b0;
      x_s1       <= '0;
      bar_px_s1  <= '0;
      bar_idx_s1 <= 3'd0;
    end else begin
      hs_s1      <= hs_i;
      vs_s1      <= vs_i;
      de_s1      <= de_i;
      x_s1       <= x_nxt;
      bar_px_s1  <= bar_px_nxt;
      bar_idx_s1 <= bar_idx_nxt;
    end
  end

  // frame bookkeeping: line counter, latched pattern, frame count, bar position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_cnt      <= '0;
      pat_q      <= 3'd0;
      frame_cnt  <= 16'd0;
      bar_pos    <= '0;
      frame_seen <= 1'b0;
    end else if (frame_start) begin
      y_cnt      <= '0;
      pat_q      <= pat_sel;
      frame_cnt  <= frame_cnt + 16'd1;
      bar_pos    <= bp_next;
      frame_seen <= 1'b1;
    end else if (run_end && (y_cnt != Y_LAST)) begin
      y_cnt <= y_cnt + 1'b1;
    end
  end

  // sticky run-length check; partial runs cut by reset before the first frame are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_run  <= 1'b0;
      line_err <= 1'b0;
    end else begin
      if (run_start) begin
        chk_run <= frame_seen | frame_start;
      end
      if (run_end && chk_run && (x_s1 != X_LAST)) begin
        line_err <= 1'b1;
      end
    end
  end

  // pattern colour for the stage-1 pixel; y_cnt is stable for the pixel it belongs to
  always_comb begin
    grad   = 8'(x_s1);
    x_ext  = {1'b0, x_s1};
    bp_ext = {1'b0, bar_pos};
    pix    = 24'h000000;
    case (pat_q)
      3'd0: begin
        case (bar_idx_s1)
          3'd0:    pix = 24'hFFFFFF;
          3'd1:    pix = 24'hFFFF00;
          3'd2:    pix = 24'h00FFFF;
          3'd3:    pix = 24'h00FF00;
          3'd4:    pix = 24'hFF00FF;
          3'd5:    pix = 24'hFF0000;
          3'd6:    pix = 24'h0000FF;
          default: pix = 24'h000000;
        endcase
      end
      3'd1:    pix = {grad, grad, grad};
      3'd2:    pix = (x_s1[CHK_SHIFT] ^ y_cnt[CHK_SHIFT]) ? 24'hFFFFFF : 24'h000000;
      3'd3:    pix = ((x_ext >= bp_ext) && (x_ext < bp_ext + BAR_EXT)) ? 24'hFFFFFF : 24'h000000;
      3'd4:    pix = solid_rgb;
      default: pix = 24'h000000;
    endcase
  end

  // stage 2: output registers; colour is forced black outside active video
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_o  <= SYNC_IDLE;
      vs_o  <= SYNC_IDLE;
      de_o  <= 1'b0;
      rgb_o <= 24'h000000;
    end else begin
      hs_o  <= hs_s1;
      vs_o  <= vs_s1;
      de_o  <= de_s1;
      rgb_o <= (de_s1 && frame_seen) ? pix : 24'h000000;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: a 12x12 timing generator (8x6 active) drives the block,
// every output cycle is compared with the input two cycles earlier plus the expected colour.
module tb_video_pattern_gen;

  localparam int H = 8;
  localparam int V = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        hs_i, vs_i, de_i;
  logic [2:0]  pat_sel;
  logic [23:0] solid_rgb;
  logic        hs_o, vs_o, de_o;
  logic [23:0] rgb_o;
  logic [15:0] frame_cnt;
  logic        line_err;

  video_pattern_gen #(
    .H_ACTIVE(8), .V_ACTIVE(6), .SYNC_ACT_LOW(1), .CHK_SHIFT(0), .MOVE_STEP(1)
  ) dut (
    .clk(clk), .rst(rst), .hs_i(hs_i), .vs_i(vs_i), .de_i(de_i),
    .pat_sel(pat_sel), .solid_rgb(solid_rgb),
    .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o), .rgb_o(rgb_o),
    .frame_cnt(frame_cnt), .line_err(line_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // timing generator and reference state
  int   hcnt = 0;
  int   vcnt = 6;
  logic inj = 1'b0;
  logic inj_de = 1'b0;
  bit   started = 1'b0;
  int   mpat = 0;
  int   mbar = 0;
  logic prev_vs_act = 1'b0;

  logic [23:0] bars [8];
  logic [23:0] row0 [8];
  logic [23:0] row1 [8];
  logic [23:0] rowl [8];

  // values driven one and two cycles ago
  logic        d1_hs = 1'b1, d1_vs = 1'b1, d1_de = 1'b0;
  logic [23:0] d1_rgb = 24'h0;
  int          d1_x = 0, d1_y = 0;
  logic        d2_hs = 1'b1, d2_vs = 1'b1, d2_de = 1'b0;
  logic [23:0] d2_rgb = 24'h0;
  int          d2_x = 0, d2_y = 0;

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] exp_pix(input int pat, input int x, input int y);
    logic [7:0] g;
    g = 8'(x);
    case (pat)
      0:       return bars[(x > 7) ? 7 : x];
      1:       return {g, g, g};
      2:       return (((x ^ y) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      3:       return (x == mbar) ? 24'hFFFFFF : 24'h000000;
      4:       return solid_rgb;
      default: return 24'h000000;
    endcase
  endfunction

  // one pixel clock: check outputs against inputs of two cycles ago, then drive the next inputs
  task automatic tick();
    logic n_hs, n_vs, n_de, vs_act;
    int   y;
    @(posedge clk);
    #1;
    chk("hs_o", 24'(hs_o), 24'(d2_hs));
    chk("vs_o", 24'(vs_o), 24'(d2_vs));
    chk("de_o", 24'(de_o), 24'(d2_de));
    chk("rgb_o", rgb_o, d2_rgb);
    if (d2_de && d2_x < 8) begin
      if (d2_y == 0) row0[d2_x] = rgb_o;
      if (d2_y == 1) row1[d2_x] = rgb_o;
      if (d2_y == 5) rowl[d2_x] = rgb_o;
    end
    d2_hs = d1_hs; d2_vs = d1_vs; d2_de = d1_de; d2_rgb = d1_rgb; d2_x = d1_x; d2_y = d1_y;

    n_de = inj ? inj_de : ((hcnt < H) && (vcnt < V));
    n_hs = !((hcnt == 9) || (hcnt == 10));
    n_vs = !((vcnt == 8) || (vcnt == 9));
    vs_act = !n_vs;
    if (vs_act && !prev_vs_act) begin
      started = 1'b1;
      mpat    = int'(pat_sel);
      mbar    = (mbar + 1) % H;
    end
    prev_vs_act = vs_act;
    y = (vcnt < V) ? vcnt : V - 1;

    hs_i = n_hs; vs_i = n_vs; de_i = n_de;
    d1_hs = n_hs; d1_vs = n_vs; d1_de = n_de;
    d1_x = hcnt; d1_y = y;
    d1_rgb = (n_de && started) ? exp_pix(mpat, hcnt, y) : 24'h000000;

    if (hcnt == 11) begin
      hcnt = 0;
      vcnt = (vcnt == 11) ? 0 : vcnt + 1;
    end else begin
      hcnt = hcnt + 1;
    end
  endtask

  task automatic run_frame();
    repeat (144) tick();
  endtask

  initial begin
    bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
    bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
    for (int i = 0; i < 8; i++) begin
      row0[i] = 24'hDEAD00; row1[i] = 24'hDEAD00; rowl[i] = 24'hDEAD00;
    end

    // reset state
    rst = 1'b1; hs_i = 1'b1; vs_i = 1'b1; de_i = 1'b0; pat_sel = 3'd0; solid_rgb = 24'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hs_o", 24'(hs_o), 24'h1);
    chk("rst_vs_o", 24'(vs_o), 24'h1);
    chk("rst_de_o", 24'(de_o), 24'h0);
    chk("rst_rgb_o", rgb_o, 24'h0);
    chk("rst_frame_cnt", 24'(frame_cnt), 24'h0);
    chk("rst_line_err", 24'(line_err), 24'h0);
    rst = 1'b0;

    // frame 1: colour bars
    pat_sel = 3'd0;
    run_frame();
    chk("frame_cnt_1", 24'(frame_cnt), 24'd1);
    for (int i = 0; i < 8; i++) chk("bars_row0", row0[i], bars[i]);

    // frame 2: gradient
    pat_sel = 3'd1;
    run_frame();
    chk("frame_cnt_2", 24'(frame_cnt), 24'd2);
    chk("grad_x0", row0[0], 24'h000000);
    chk("grad_x3", row1[3], 24'h030303);
    chk("grad_x7", row0[7], 24'h070707);

    // frame 3: checkerboard
    pat_sel = 3'd2;
    run_frame();
    chk("chk_r0x0", row0[0], 24'h000000);
    chk("chk_r0x1", row0[1], 24'hFFFFFF);
    chk("chk_r1x0", row1[0], 24'hFFFFFF);
    chk("chk_r1x1", row1[1], 24'h000000);

    // frames 4..8: moving bar, bar_pos equals frame number modulo 8
    pat_sel = 3'd3;
    repeat (4) run_frame();
    chk("bar_f7_x7", row0[7], 24'hFFFFFF);
    chk("bar_f7_x6", row0[6], 24'h000000);
    run_frame();
    chk("frame_cnt_8", 24'(frame_cnt), 24'd8);
    chk("bar_f8_x0", row0[0], 24'hFFFFFF);
    chk("bar_f8_x1", row0[1], 24'h000000);
    chk("line_err_clean", 24'(line_err), 24'h0);

    // frame 9: bars, switch to solid in the middle of line 2
    pat_sel = 3'd0;
    repeat (72 + 27) tick();
    pat_sel = 3'd4;
    solid_rgb = 24'h123456;
    repeat (144 - 72 - 27) tick();
    chk("switch_row0", row0[2], 24'h00FFFF);
    chk("switch_rowl", rowl[1], 24'hFFFF00);

    // frame 10: solid
    run_frame();
    chk("frame_cnt_10", 24'(frame_cnt), 24'd10);
    chk("solid_row0", row0[5], 24'h123456);
    chk("solid_rowl", rowl[7], 24'h123456);
    chk("line_err_pre", 24'(line_err), 24'h0);

    // short 7-pixel run in vertical blanking
    inj = 1'b1; inj_de = 1'b1;
    repeat (7) tick();
    inj_de = 1'b0;
    repeat (3) tick();
    inj = 1'b0;
    chk("line_err_set", 24'(line_err), 24'h1);
    repeat (134) tick();
    chk("line_err_sticky", 24'(line_err), 24'h1);
    chk("frame_cnt_11", 24'(frame_cnt), 24'd11);

    // asynchronous reset in the middle of an active line
    repeat (72 + 4) tick();
    chk("pre_rst_de_o", 24'(de_o), 24'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_hs_o", 24'(hs_o), 24'h1);
    chk("mid_rst_vs_o", 24'(vs_o), 24'h1);
    chk("mid_rst_de_o", 24'(de_o), 24'h0);
    chk("mid_rst_rgb_o", rgb_o, 24'h0);
    chk("mid_rst_frame_cnt", 24'(frame_cnt), 24'h0);
    chk("mid_rst_line_err", 24'(line_err), 24'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
